// File: rtl/esfa_pkg.sv
// Types and default constants shared by the ESFA run sequencer and its sample buffer.
package esfa_pkg;

    // Run sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Default symbol width, buffer depth and result timeout.
    localparam int DEFAULT_SYM_W   = 8;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage : esfa_pkg

// File: rtl/esfa_sample_buf.sv
// Sample buffer: symbols are written sequentially at the current count and
// read back by index. A clear-and-write restarts the sample at slot 0.
module esfa_sample_buf
    import esfa_pkg::*;
#(
    parameter int SYM_W = DEFAULT_SYM_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [SYM_W-1:0]           wr_sym,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [SYM_W-1:0]           rd_sym,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0] count_reg;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_ok;
    logic             full_int;
    logic [SYM_W-1:0] slot_data [DEPTH];

    assign full_int = (count_reg == CNT_W'(DEPTH));
    // A clearing write replaces the whole sample, so a full buffer does not block it.
    assign wr_ok    = wr_en && (clr || !full_int);
    assign wr_idx   = clr ? '0 : count_reg[IDX_W-1:0];

    // Fill level: restarts at one on a clearing write, otherwise counts accepted writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (wr_ok) begin
            count_reg <= clr ? CNT_W'(1) : count_reg + CNT_W'(1);
        end
    end

    // One register per slot; contents are don't-care until written, so no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [SYM_W-1:0] slot_reg;

            // Capture the symbol when this slot is the write target.
            always_ff @(posedge clk) begin
                if (wr_ok && (wr_idx == IDX_W'(gi))) begin
                    slot_reg <= wr_sym;
                end
            end

            assign slot_data[gi] = slot_reg;
        end
    endgenerate

    assign rd_sym = slot_data[rd_idx];
    assign count  = count_reg;
    assign full   = full_int;

endmodule : esfa_sample_buf

// File: rtl/esfa_run_sequencer.sv
// ESFA run sequencer: buffers a host sample, initialises the core, streams the
// symbols over valid/ready and reports the core verdict (or a timeout).
module esfa_run_sequencer
    import esfa_pkg::*;
#(
    parameter int SYM_W        = DEFAULT_SYM_W,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    parameter bit ACCEPT_EMPTY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SYM_W-1:0] wr_sym,
    output logic             wr_full,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             accept,
    output logic             timed_out,
    output logic             core_init,
    output logic [SYM_W-1:0] core_sym,
    output logic             core_sym_valid,
    output logic             core_sym_last,
    input  logic             core_sym_ready,
    input  logic             core_res_valid,
    input  logic             core_res_accept
);

    localparam int RD_W  = $clog2(DEPTH);
    localparam int CNT_W = RD_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    state_t           state_reg;
    logic [RD_W-1:0]  rd_reg;
    logic [TMR_W-1:0] timer_reg;
    logic             core_init_reg;
    logic             valid_reg;
    logic             done_reg;
    logic             accept_reg;
    logic             timed_out_reg;
    // Set once a run completes: the next host write starts a fresh sample.
    logic             fresh_reg;

    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic [SYM_W-1:0] buf_rd_sym;
    logic             host_phase;
    logic             buf_clr;
    logic             buf_wr;
    logic             is_last;
    logic             xfer;
    logic             have_sample;

    assign host_phase  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign buf_wr      = wr_en && host_phase;
    assign buf_clr     = buf_wr && (state_reg == ST_DONE) && fresh_reg;
    assign is_last     = (CNT_W'(rd_reg) == (buf_count - CNT_W'(1)));
    assign xfer        = valid_reg && core_sym_ready;
    assign have_sample = (buf_count != '0);

    esfa_sample_buf #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .wr_en  (buf_wr),
        .wr_sym (wr_sym),
        .rd_idx (rd_reg),
        .rd_sym (buf_rd_sym),
        .count  (buf_count),
        .full   (buf_full)
    );

    // Run FSM with result timer and registered control/verdict outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rd_reg        <= '0;
            timer_reg     <= '0;
            core_init_reg <= 1'b0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
            accept_reg    <= 1'b0;
            timed_out_reg <= 1'b0;
            fresh_reg     <= 1'b0;
        end else begin
            core_init_reg <= 1'b0;
            done_reg      <= 1'b0;
            if (buf_wr) begin
                fresh_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        timed_out_reg <= 1'b0;
                        if (have_sample) begin
                            state_reg     <= ST_INIT;
                            core_init_reg <= 1'b1;
                            accept_reg    <= 1'b0;
                            rd_reg        <= '0;
                            fresh_reg     <= 1'b0;
                        end else begin
                            // Nothing to stream: report the empty-sample verdict directly.
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            accept_reg <= ACCEPT_EMPTY;
                            fresh_reg  <= 1'b1;
                        end
                    end
                end

                ST_INIT: begin
                    state_reg <= ST_STREAM;
                    valid_reg <= 1'b1;
                    rd_reg    <= '0;
                end

                ST_STREAM: begin
                    // Result strobes here are ignored; the core must answer after the last symbol.
                    if (xfer) begin
                        if (is_last) begin
                            state_reg <= ST_WAIT;
                            valid_reg <= 1'b0;
                            timer_reg <= '0;
                        end else begin
                            rd_reg <= rd_reg + RD_W'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    // A result on the expiry cycle still counts as a real verdict.
                    if (core_res_valid) begin
                        state_reg  <= ST_DONE;
                        accept_reg <= core_res_accept;
                        done_reg   <= 1'b1;
                        fresh_reg  <= 1'b1;
                    end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                        state_reg     <= ST_DONE;
                        accept_reg    <= 1'b0;
                        timed_out_reg <= 1'b1;
                        done_reg      <= 1'b1;
                        fresh_reg     <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = (state_reg == ST_INIT) || (state_reg == ST_STREAM) ||
                            (state_reg == ST_WAIT);
    assign done           = done_reg;
    assign accept         = accept_reg;
    assign timed_out      = timed_out_reg;
    assign core_init      = core_init_reg;
    assign core_sym_valid = valid_reg;
    // Data is forced to zero when not valid so idle/reset outputs read as 0.
    assign core_sym       = valid_reg ? buf_rd_sym : '0;
    assign core_sym_last  = valid_reg && is_last;
    assign wr_full        = buf_full;

endmodule : esfa_run_sequencer

// File: tb/tb_esfa_run_sequencer.sv
// Self-checking bench for esfa_run_sequencer: table of runs plus hand sequences
// for the empty sample and reset during streaming.
module tb_esfa_run_sequencer;

    localparam int SYM_W        = 8;
    localparam int DEPTH        = 16;
    localparam int TIMEOUT      = 64;
    localparam bit ACCEPT_EMPTY = 1'b0;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [SYM_W-1:0] wr_sym;
    logic             wr_full;
    logic             start;
    logic             busy;
    logic             done;
    logic             accept;
    logic             timed_out;
    logic             core_init;
    logic [SYM_W-1:0] core_sym;
    logic             core_sym_valid;
    logic             core_sym_last;
    logic             core_sym_ready;
    logic             core_res_valid;
    logic             core_res_accept;

    esfa_run_sequencer #(
        .SYM_W        (SYM_W),
        .DEPTH        (DEPTH),
        .TIMEOUT      (TIMEOUT),
        .ACCEPT_EMPTY (ACCEPT_EMPTY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_sym          (wr_sym),
        .wr_full         (wr_full),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .accept          (accept),
        .timed_out       (timed_out),
        .core_init       (core_init),
        .core_sym        (core_sym),
        .core_sym_valid  (core_sym_valid),
        .core_sym_last   (core_sym_last),
        .core_sym_ready  (core_sym_ready),
        .core_res_valid  (core_res_valid),
        .core_res_accept (core_res_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [SYM_W-1:0] sym;
        logic             last;
    } xfer_t;

    typedef struct {
        int               n_wr;
        logic [SYM_W-1:0] base;
        int               mode;     // 0 ready always, 1 toggle pattern, 2 never ready
        int               delay;    // cycles after last transfer; -1 = never answer
        logic             racc;
        logic             exp_acc;
        logic             exp_to;
        int               exp_n;
        bit               timing;
    } case_t;

    xfer_t            exp_q [$];
    logic [SYM_W-1:0] model_buf [$];
    bit               model_fresh = 1'b0;

    int   ready_mode   = 0;
    int   resp_delay   = -1;
    logic resp_acc_cfg = 1'b0;
    int   xfer_cnt     = 0;
    int   init_cnt     = 0;
    int   cyc          = 0;
    int   last_edge    = 0;
    int   resp_cnt     = 0;
    bit   resp_armed   = 1'b0;
    int   pat_idx      = 0;
    bit   prev_stall   = 1'b0;
    bit   stall_chk_en = 1'b1;
    logic [SYM_W-1:0] prev_sym  = '0;
    logic             prev_last = 1'b0;
    bit   toggle_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: drives ready/result and scores every symbol transfer.
    always @(negedge clk) begin
        if (prev_stall && stall_chk_en) begin
            check("stall_valid", int'(core_sym_valid), 1);
            check("stall_sym", int'(core_sym), int'(prev_sym));
            check("stall_last", int'(core_sym_last), int'(prev_last));
        end
        core_res_valid = 1'b0;
        if (resp_armed) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                core_res_valid  = 1'b1;
                core_res_accept = resp_acc_cfg;
                resp_armed      = 1'b0;
            end
        end
        if (core_sym_valid) begin
            case (ready_mode)
                0:       core_sym_ready = 1'b1;
                1:       core_sym_ready = toggle_pat[pat_idx % 6];
                default: core_sym_ready = 1'b0;
            endcase
            pat_idx++;
        end else begin
            core_sym_ready = (ready_mode == 0);
        end
        prev_stall = core_sym_valid && !core_sym_ready;
        prev_sym   = core_sym;
        prev_last  = core_sym_last;
        if (core_sym_valid && core_sym_ready) begin
            xfer_t e;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got sym %0h expected no transfer", core_sym);
            end else begin
                e = exp_q.pop_front();
                check("xfer_sym", int'(core_sym), int'(e.sym));
                check("xfer_last", int'(core_sym_last), int'(e.last));
            end
            if (core_sym_last) begin
                last_edge = cyc + 1;
                if (resp_delay > 0) begin
                    resp_armed = 1'b1;
                    resp_cnt   = resp_delay;
                end
            end
        end
        if (core_init) init_cnt++;
    end

    task automatic write_sym(input logic [SYM_W-1:0] s);
        if (model_fresh) begin
            model_buf.delete();
            model_fresh = 1'b0;
        end
        if (model_buf.size() < DEPTH) model_buf.push_back(s);
        wr_en  = 1'b1;
        wr_sym = s;
        @(negedge clk);
        wr_en  = 1'b0;
        check("wr_full", int'(wr_full), int'(model_buf.size() == DEPTH));
    endtask

    task automatic run_case(input int idx, input case_t c);
        xfer_t e;
        bit    seen;
        exp_q.delete();
        for (int i = 0; i < model_buf.size(); i++) begin
            e.sym  = model_buf[i];
            e.last = (i == model_buf.size() - 1);
            exp_q.push_back(e);
        end
        ready_mode   = c.mode;
        resp_delay   = c.delay;
        resp_acc_cfg = c.racc;
        xfer_cnt     = 0;
        init_cnt     = 0;
        pat_idx      = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("init_latency", int'(core_init), 1);
        check("busy_init", int'(busy), 1);
        check("valid_in_init", int'(core_sym_valid), 0);
        @(negedge clk);
        check("first_valid", int'(core_sym_valid), 1);
        check("init_one_cycle", int'(core_init), 0);
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
        check("accept", int'(accept), int'(c.exp_acc));
        check("timed_out", int'(timed_out), int'(c.exp_to));
        check("busy_done", int'(busy), 0);
        check("xfer_count", xfer_cnt, c.exp_n);
        check("init_count", init_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        if (c.timing) check("timeout_cycles", cyc - last_edge, TIMEOUT);
        $display("run %0d: syms=%0d xfers=%0d accept=%0b timed_out=%0b", idx,
                 model_buf.size(), xfer_cnt, accept, timed_out);
        model_fresh = 1'b1;
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        check("accept_held", int'(accept), int'(c.exp_acc));
    endtask

    case_t cases [6];

    initial begin
        int done_cnt;
        cases[0] = '{3,  8'h61, 0,  2, 1'b1, 1'b1, 1'b0, 3,  1'b0};
        cases[1] = '{0,  8'h00, 1,  2, 1'b0, 1'b0, 1'b0, 3,  1'b0};
        cases[2] = '{0,  8'h00, 0, -1, 1'b0, 1'b0, 1'b1, 3,  1'b1};
        cases[3] = '{17, 8'h10, 0,  1, 1'b1, 1'b1, 1'b0, 16, 1'b0};
        cases[4] = '{0,  8'h00, 1,  3, 1'b1, 1'b1, 1'b0, 16, 1'b0};
        cases[5] = '{1,  8'hA5, 0,  3, 1'b1, 1'b1, 1'b0, 1,  1'b0};

        rst = 1'b1; wr_en = 1'b0; wr_sym = '0; start = 1'b0;
        core_sym_ready = 1'b0; core_res_valid = 1'b0; core_res_accept = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_accept", int'(accept), 0);
        check("rst_timed_out", int'(timed_out), 0);
        check("rst_core_init", int'(core_init), 0);
        check("rst_valid", int'(core_sym_valid), 0);
        check("rst_wr_full", int'(wr_full), 0);
        rst = 1'b0;
        @(negedge clk);

        // Empty sample: immediate verdict, no core_init.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_core_init", int'(core_init), 0);
        check("empty_done", int'(done), 1);
        check("empty_accept", int'(accept), int'(ACCEPT_EMPTY));
        check("empty_busy", int'(busy), 0);
        $display("empty run: done=%0b accept=%0b", done, accept);
        @(negedge clk);
        check("empty_done_pulse", int'(done), 0);
        model_fresh = 1'b1;

        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < cases[c].n_wr; i++) write_sym(SYM_W'(cases[c].base + i));
            run_case(c, cases[c]);
        end

        // Reset while stalled in STREAM: everything clears, no done pulse.
        for (int i = 0; i < 4; i++) write_sym(SYM_W'(8'hC0 + i));
        stall_chk_en = 1'b0;
        ready_mode   = 2;
        resp_delay   = -1;
        exp_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_streaming", int'(core_sym_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", int'(core_sym_valid), 0);
        check("mid_rst_sym", int'(core_sym), 0);
        check("mid_rst_last", int'(core_sym_last), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_accept", int'(accept), 0);
        check("mid_rst_core_init", int'(core_init), 0);
        check("mid_rst_wr_full", int'(wr_full), 0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        $display("reset run: done pulses after reset=%0d", done_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_esfa_run_sequencer
